// File: rtl/hilo_ctrl.sv
// hilo_ctrl: sequences the iterative mult/div unit and holds the HI/LO pair.
// An operation restarts the unit (CLR), waits a fixed 33 iterations (RUN),
// then commits the unit's result into HI/LO or flags divide-by-zero (LATCH).
module hilo_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op_div,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wr_data,
    input  logic [31:0] md_high,
    input  logic [31:0] md_low,
    input  logic        md_zero,
    output logic        md_reset,
    output logic        md_set,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned ITER     = 33;
    localparam logic [5:0]  CNT_LAST = 6'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        RUN,
        LATCH
    } state_t;

    state_t      state, state_d;
    logic [5:0]  cnt, cnt_d;
    logic        op_q, op_d;
    logic [31:0] hi_d, lo_d;
    logic        done_d, dz_d;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Datapath registers: iteration counter, latched op, HI/LO, result pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            op_q     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            cnt      <= cnt_d;
            op_q     <= op_d;
            hi       <= hi_d;
            lo       <= lo_d;
            done     <= done_d;
            div_zero <= dz_d;
        end
    end

    // Next-state and next-value logic; moves are only honoured in IDLE
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        op_d    = op_q;
        hi_d    = hi;
        lo_d    = lo;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        case (state)
            IDLE: begin
                if (mthi) hi_d = wr_data;
                if (mtlo) lo_d = wr_data;
                if (start) begin
                    op_d    = op_div;
                    state_d = CLR;
                end
            end
            CLR: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                if (cnt == CNT_LAST) begin
                    state_d = LATCH;
                end else begin
                    cnt_d = cnt + 6'd1;
                end
            end
            LATCH: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (op_q && md_zero) begin
                    dz_d = 1'b1;
                end else begin
                    hi_d = md_high;
                    lo_d = md_low;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign md_reset = reset | (state == CLR);
    assign md_set   = op_q;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: expected HI/LO/div_zero and completion
// cycle are queued at each start and compared when done pulses.
module tb_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, op_div, mthi, mtlo, md_zero;
    logic [31:0] wr_data, md_high, md_low;
    logic        md_reset, md_set, busy, done, div_zero;
    logic [31:0] hi, lo;

    hilo_ctrl dut (
        .clk      (clk),
        .reset    (rst),
        .start    (start),
        .op_div   (op_div),
        .mthi     (mthi),
        .mtlo     (mtlo),
        .wr_data  (wr_data),
        .md_high  (md_high),
        .md_low   (md_low),
        .md_zero  (md_zero),
        .md_reset (md_reset),
        .md_set   (md_set),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_hi, model_lo;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", done, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("hi", hi, e.hi);
                check("lo", lo, e.lo);
                check("div_zero", div_zero, e.dz);
                check("done_cycle", cyc, e.cyc);
            end
        end
        if (!rst && !done) check("dz_without_done", div_zero, 1'b0);
    end

    // Launch one operation and track it cycle by cycle up to its completion.
    // poke: in cycle 10 issue an ignored start plus mtlo. mv: mthi alongside start.
    task automatic do_op(input logic div, input logic [31:0] a, input logic [31:0] b,
                         input logic poke, input logic mv);
        logic signed [31:0] sa, sbv;
        logic signed [63:0] p;
        exp_t e;
        sa = a;
        sbv = b;
        if (mv) model_hi = 32'hCAFE0001;
        if (div) begin
            if (b == 32'd0) begin
                md_zero = 1'b1;
                md_high = 32'hBAD0BAD0;
                md_low  = 32'hBAD1BAD1;
                e.hi = model_hi;
                e.lo = model_lo;
                e.dz = 1'b1;
            end else begin
                md_zero = 1'b0;
                md_high = sa % sbv;
                md_low  = sa / sbv;
                e.hi = md_high;
                e.lo = md_low;
                e.dz = 1'b0;
            end
        end else begin
            p = sa * sbv;
            md_zero = 1'b1;          // must be ignored for a multiply
            md_high = p[63:32];
            md_low  = p[31:0];
            e.hi = md_high;
            e.lo = md_low;
            e.dz = 1'b0;
        end
        model_hi = e.hi;
        model_lo = e.lo;
        e.cyc = cyc + 36;
        sb.push_back(e);

        op_div  = div;
        start   = 1'b1;
        mthi    = mv;
        wr_data = 32'hCAFE0001;
        tick();
        start  = 1'b0;
        mthi   = 1'b0;
        op_div = ~div;
        for (int k = 1; k <= 35; k++) begin
            check("busy_run", busy, 1'b1);
            check("md_set", md_set, div);
            check("md_reset", md_reset, (k == 1));
            if (poke && k == 10) begin
                start   = 1'b1;
                mtlo    = 1'b1;
                wr_data = 32'h0BADF00D;
                tick();
                start = 1'b0;
                mtlo  = 1'b0;
            end else begin
                tick();
            end
        end
        check("busy_end", busy, 1'b0);
        check("done_end", done, 1'b1);
        op_div = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 0; op_div = 0; mthi = 0; mtlo = 0; md_zero = 0;
        wr_data = '0; md_high = '0; md_low = '0;
        model_hi = '0; model_lo = '0;
        tick();
        tick();
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dz", div_zero, 1'b0);
        check("rst_md_set", md_set, 1'b0);
        check("rst_md_reset", md_reset, 1'b1);
        rst = 1'b0;
        tick();
        check("md_reset_idle", md_reset, 1'b0);

        // Multiply 7 * -3
        do_op(1'b0, 32'd7, -32'sd3, 1'b0, 1'b0);
        tick();
        check("done_clear", done, 1'b0);

        // Divide -7 / 2
        do_op(1'b1, -32'sd7, 32'd2, 1'b0, 1'b0);
        tick();

        // Preload then divide by zero: HI/LO must survive
        mthi = 1'b1; wr_data = 32'h11111111; tick(); mthi = 1'b0;
        mtlo = 1'b1; wr_data = 32'h22222222; tick(); mtlo = 1'b0;
        model_hi = 32'h11111111;
        model_lo = 32'h22222222;
        check("mthi_pre", hi, 32'h11111111);
        check("mtlo_pre", lo, 32'h22222222);
        do_op(1'b1, 32'd5, 32'd0, 1'b0, 1'b0);
        check("dz_pulse", div_zero, 1'b1);
        tick();
        check("dz_clear", div_zero, 1'b0);
        check("done_clear2", done, 1'b0);

        // Moves in IDLE, both together
        mthi = 1'b1; wr_data = 32'hDEADBEEF; tick(); mthi = 1'b0;
        check("mthi", hi, 32'hDEADBEEF);
        mthi = 1'b1; mtlo = 1'b1; wr_data = 32'h01234567; tick();
        mthi = 1'b0; mtlo = 1'b0;
        check("both_hi", hi, 32'h01234567);
        check("both_lo", lo, 32'h01234567);
        model_hi = 32'h01234567;
        model_lo = 32'h01234567;

        // Ignored start + mtlo mid-operation, then back-to-back operations
        do_op(1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0);
        do_op(1'b1, 32'd1000, -32'sd7, 1'b0, 1'b0);
        tick();

        // mthi in the same cycle as start: divide by zero keeps the moved HI
        do_op(1'b1, 32'd9, 32'd0, 1'b0, 1'b1);
        tick();
        check("mv_dz_hi", hi, 32'hCAFE0001);
        // mthi with start on a multiply: result overwrites it
        do_op(1'b0, -32'sd1, -32'sd1, 1'b0, 1'b1);
        tick();

        // Reset mid-run: no done, HI/LO cleared
        md_zero = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_hi", hi, 32'h0);
        check("mid_rst_lo", lo, 32'h0);
        check("mid_rst_md_reset", md_reset, 1'b1);
        tick();
        check("mid_rst_done", done, 1'b0);
        rst = 1'b0;
        model_hi = '0;
        model_lo = '0;
        repeat (40) tick();
        check("post_rst_idle", busy, 1'b0);
        do_op(1'b0, 32'd100, 32'd200, 1'b0, 1'b0);
        tick();
        tick();

        check("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
